// File: rtl/mfc_operand_sequencer.sv
// ---------------------------------------------------------------------------
// mfc_operand_sequencer
//
// Operand feed and result capture for the 16-bit multi-function comparator
// (eq / ae / gt / nibble-equal d). The comparator is purely combinational
// with a long propagation delay. This block therefore:
//   1. takes A and then B from one 16-bit valid/ready stream,
//   2. holds them steady on op_a / op_b,
//   3. waits SETTLE_CYCLES edges after B is loaded,
//   4. registers the comparator flags and pulses done for one cycle.
//
// Optional feature (compile-time macro MFC_MATCH_COUNT_EN):
//   Adds an 8-bit saturating counter, match_cnt. It counts captures where
//   cmp_eq was 1 and is cleared only by reset. When the macro is not defined,
//   the port and its logic are not present.
//
// Parameters:
//   SETTLE_CYCLES - edges from the B load to the flag capture. Must be >= 1.
//                   The default of 58 covers a 576 ns comparator at 10 ns.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   synchronous reset, active low
//   start      in   begin a comparison (accepted only in IDLE)
//   din[15:0]  in   operand data, A first then B
//   din_valid  in   din holds an operand
//   din_ready  out  an operand can be accepted this cycle
//   op_a[15:0] out  registered A to the comparator
//   op_b[15:0] out  registered B to the comparator
//   cmp_eq/ae/gt, cmp_d[3:0]  in  comparator flags
//   eq/ae/gt, d[3:0]          out captured flags
//   match_cnt[7:0] out  saturating equal-capture count (optional)
//   busy       out  not in IDLE
//   done       out  one-cycle pulse on flag capture
// ---------------------------------------------------------------------------
module mfc_operand_sequencer #(
    parameter int SETTLE_CYCLES = 58
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] din,
    input  logic        din_valid,
    output logic        din_ready,
    output logic [15:0] op_a,
    output logic [15:0] op_b,
    input  logic        cmp_eq,
    input  logic        cmp_ae,
    input  logic        cmp_gt,
    input  logic [3:0]  cmp_d,
    output logic        eq,
    output logic        ae,
    output logic        gt,
    output logic [3:0]  d,
`ifdef MFC_MATCH_COUNT_EN
    output logic [7:0]  match_cnt,
`endif
    output logic        busy,
    output logic        done
);

    localparam int CW = $clog2(SETTLE_CYCLES + 1);
    // The counter is loaded with SETTLE_CYCLES-1 on the B-load edge and
    // captures when it reads 0. That places the capture SETTLE_CYCLES edges
    // after the B load.
    localparam logic [CW-1:0] CNT_LOAD = CW'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD_A,
        S_LOAD_B,
        S_SETTLE
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [CW-1:0]   r_cnt;
    logic [15:0]     r_op_a;
    logic [15:0]     r_op_b;
    logic            r_eq;
    logic            r_ae;
    logic            r_gt;
    logic [3:0]      r_d;
    logic            r_busy;
    logic            r_done;
    logic            w_load_a;
    logic            w_load_b;
    logic            w_capture;
    logic            w_din_ready;

    // ---------------- state register ----------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ---------------- next state / strobes ----------------
    always_comb begin
        w_next      = r_state;
        w_load_a    = 1'b0;
        w_load_b    = 1'b0;
        w_capture   = 1'b0;
        w_din_ready = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = S_LOAD_A;
                end
            end
            S_LOAD_A: begin
                w_din_ready = 1'b1;
                if (din_valid) begin
                    w_load_a = 1'b1;
                    w_next   = S_LOAD_B;
                end
            end
            S_LOAD_B: begin
                w_din_ready = 1'b1;
                if (din_valid) begin
                    w_load_b = 1'b1;
                    w_next   = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (r_cnt == '0) begin
                    w_capture = 1'b1;
                    w_next    = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt  <= '0;
            r_op_a <= '0;
            r_op_b <= '0;
            r_eq   <= 1'b0;
            r_ae   <= 1'b0;
            r_gt   <= 1'b0;
            r_d    <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= w_capture;
            // busy is registered from the next state, so it is clean and
            // matches "not IDLE" in every cycle, including the done cycle.
            r_busy <= (w_next != S_IDLE);

            if (w_load_a) begin
                r_op_a <= din;
            end

            if (w_load_b) begin
                r_op_b <= din;
                r_cnt  <= CNT_LOAD;
            end else if (r_state == S_SETTLE && r_cnt != '0) begin
                r_cnt <= r_cnt - 1'b1;
            end

            if (w_capture) begin
                r_eq <= cmp_eq;
                r_ae <= cmp_ae;
                r_gt <= cmp_gt;
                r_d  <= cmp_d;
            end
        end
    end

`ifdef MFC_MATCH_COUNT_EN
    logic [7:0] r_match_cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_match_cnt <= '0;
        end else if (w_capture && cmp_eq && r_match_cnt != 8'hFF) begin
            r_match_cnt <= r_match_cnt + 8'd1;
        end
    end

    assign match_cnt = r_match_cnt;
`endif

    assign din_ready = w_din_ready;
    assign op_a      = r_op_a;
    assign op_b      = r_op_b;
    assign eq        = r_eq;
    assign ae        = r_ae;
    assign gt        = r_gt;
    assign d         = r_d;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule

// File: tb/tb_mfc_operand_sequencer.sv
// ---------------------------------------------------------------------------
// tb_mfc_operand_sequencer
//
// Bench for mfc_operand_sequencer with SETTLE_CYCLES = 58 and a 10 ns clock.
//
// The attached comparator is a behavioural model with the following functions:
//   eq - A == B
//   ae - |A| == |B|, with A and B read as signed values
//   gt - A > B, signed
//   d  - per-nibble equality
//
// The model's flags become correct only after op_a/op_b have been stable for
// SETTLE-1 falling edges. Before that, the model drives the inverted flags.
// A capture that happens early therefore picks up wrong flags.
// ---------------------------------------------------------------------------
module tb_mfc_operand_sequencer;

    localparam int SETTLE = 58;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [15:0] din = '0;
    logic        din_valid = 1'b0;
    logic        din_ready;
    logic [15:0] op_a;
    logic [15:0] op_b;
    logic        cmp_eq;
    logic        cmp_ae;
    logic        cmp_gt;
    logic [3:0]  cmp_d;
    logic        eq;
    logic        ae;
    logic        gt;
    logic [3:0]  d;
    logic        busy;
    logic        done;
`ifdef MFC_MATCH_COUNT_EN
    logic [7:0]  match_cnt;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mfc_operand_sequencer #(.SETTLE_CYCLES(SETTLE)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .din       (din),
        .din_valid (din_valid),
        .din_ready (din_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .cmp_eq    (cmp_eq),
        .cmp_ae    (cmp_ae),
        .cmp_gt    (cmp_gt),
        .cmp_d     (cmp_d),
        .eq        (eq),
        .ae        (ae),
        .gt        (gt),
        .d         (d),
`ifdef MFC_MATCH_COUNT_EN
        .match_cnt (match_cnt),
`endif
        .busy      (busy),
        .done      (done)
    );

    // Reference comparator. Packed result: {eq, ae, gt, d[3:0]}.
    function automatic logic [6:0] ref_cmp(input logic [15:0] a, input logic [15:0] b);
        int sa, sb, ma, mb;
        logic [3:0] dd;
        sa = int'($signed(a));
        sb = int'($signed(b));
        ma = (sa < 0) ? -sa : sa;
        mb = (sb < 0) ? -sb : sb;
        for (int i = 0; i < 4; i++) dd[i] = (a[4*i +: 4] == b[4*i +: 4]);
        return {(a == b), (ma == mb), (sa > sb), dd};
    endfunction

    // Slow comparator model. It counts falling edges of stable operands.
    logic [31:0] cm_prev = '0;
    int          cm_stable = 0;
    always @(negedge clk) begin
        logic [6:0] f;
        if ({op_a, op_b} != cm_prev) cm_stable = 0;
        else if (cm_stable < 1000) cm_stable++;
        cm_prev = {op_a, op_b};
        f = ref_cmp(op_a, op_b);
        if (cm_stable < SETTLE - 1) f = ~f;
        {cmp_eq, cmp_ae, cmp_gt, cmp_d} = f;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives start, A and B. Returns 1 ns after the B-load edge.
    task automatic load_ops(input logic [15:0] a, input logic [15:0] b);
        start = 1'b1;
        tick();
        start = 1'b0;
        din = a;
        din_valid = 1'b1;
        tick();
        din = b;
        tick();
        din_valid = 1'b0;
    endtask

    // Counts edges until done is observed. Returns -1 on timeout.
    task automatic wait_done(output int n);
        n = -1;
        for (int j = 1; j <= SETTLE + 20; j++) begin
            tick();
            if (done === 1'b1) begin
                n = j;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        tick();
        tick();
        n_vec++;
        if ({op_a, op_b} !== 32'h0) begin
            n_err++;
            $display("FAIL reset_ops: got %h/%h want 0000/0000", op_a, op_b);
        end
        n_vec++;
        if ({eq, ae, gt, d} !== 7'h0) begin
            n_err++;
            $display("FAIL reset_flags: got %b want 0000000", {eq, ae, gt, d});
        end
        n_vec++;
        if ({done, busy, din_ready} !== 3'b000) begin
            n_err++;
            $display("FAIL reset_ctl: got done/busy/rdy=%b want 000", {done, busy, din_ready});
        end
        rst = 1'b1;
        tick();
        n_vec++;
        if ({busy, din_ready} !== 2'b00) begin
            n_err++;
            $display("FAIL idle_ctl: got busy/rdy=%b want 00", {busy, din_ready});
        end
    endtask

    task automatic test_equal();
        int n;
        load_ops(16'h1234, 16'h1234);
        n_vec++;
        if ({busy, din_ready} !== 2'b10) begin
            n_err++;
            $display("FAIL settle_ctl: got busy/rdy=%b want 10", {busy, din_ready});
        end
        n_vec++;
        if ({op_a, op_b} !== 32'h1234_1234) begin
            n_err++;
            $display("FAIL eq_ops: got %h/%h want 1234/1234", op_a, op_b);
        end
        wait_done(n);
        n_vec++;
        if (n != SETTLE) begin
            n_err++;
            $display("FAIL eq_latency: got %0d want %0d", n, SETTLE);
        end
        n_vec++;
        if ({eq, ae, gt, d} !== 7'b1101111) begin
            n_err++;
            $display("FAIL eq_flags: got %b want 1101111", {eq, ae, gt, d});
        end
        n_vec++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL done_cycle_busy: got %b want 0", busy);
        end
        tick();
        n_vec++;
        if (done !== 1'b0) begin
            n_err++;
            $display("FAIL done_width: got %b want 0", done);
        end
    endtask

    task automatic test_signed_boundary();
        int bad = 0;
        load_ops(16'h8001, 16'h7FFF);
        for (int j = 1; j < SETTLE; j++) begin
            tick();
            if (op_a !== 16'h8001 || op_b !== 16'h7FFF || done !== 1'b0 || din_ready !== 1'b0)
                bad++;
        end
        n_vec++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL settle_stable: got %0d bad cycles want 0", bad);
        end
        tick();
        n_vec++;
        if (done !== 1'b1) begin
            n_err++;
            $display("FAIL sb_done_edge: got %b want 1", done);
        end
        n_vec++;
        if ({eq, ae, gt, d} !== 7'b0100000) begin
            n_err++;
            $display("FAIL sb_flags: got %b want 0100000", {eq, ae, gt, d});
        end
    endtask

    task automatic test_negative();
        int n;
        load_ops(16'h0005, 16'hFFFB);
        wait_done(n);
        n_vec++;
        if (n != SETTLE) begin
            n_err++;
            $display("FAIL neg_latency: got %0d want %0d", n, SETTLE);
        end
        n_vec++;
        if ({eq, ae, gt, d} !== 7'b0110000) begin
            n_err++;
            $display("FAIL neg_flags: got %b want 0110000", {eq, ae, gt, d});
        end
    endtask

    task automatic test_stall_and_ignore();
        int bad;
        int ndone;
        int first;
        logic [6:0] got;
        // din_valid is asserted in IDLE. It must not be consumed.
        din = 16'h5555;
        din_valid = 1'b1;
        tick();
        tick();
        din_valid = 1'b0;
        n_vec++;
        if ({op_a, op_b} !== 32'h0005_FFFB || busy !== 1'b0 || din_ready !== 1'b0) begin
            n_err++;
            $display("FAIL idle_valid: got %h/%h busy=%b rdy=%b want 0005/fffb 0 0",
                     op_a, op_b, busy, din_ready);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        bad = 0;
        for (int j = 0; j < 5; j++) begin
            din = 16'($urandom);
            tick();
            if (din_ready !== 1'b1 || busy !== 1'b1 || op_a !== 16'h0005) bad++;
        end
        n_vec++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL stall_hold: got %0d bad cycles want 0", bad);
        end
        din = 16'h0A0A;
        din_valid = 1'b1;
        tick();
        din = 16'h0B0B;
        tick();
        din_valid = 1'b0;
        bad = 0;
        ndone = 0;
        first = -1;
        got = '0;
        for (int j = 1; j <= 80; j++) begin
            start = (j == 10);
            din_valid = (j >= 20 && j <= 24);
            din = 16'hDEAD;
            tick();
            if (done === 1'b1) begin
                ndone++;
                if (first < 0) begin
                    first = j;
                    got = {eq, ae, gt, d};
                end
            end
            if (first < 0 && (din_ready !== 1'b0 || op_a !== 16'h0A0A || op_b !== 16'h0B0B)) bad++;
        end
        start = 1'b0;
        din_valid = 1'b0;
        n_vec++;
        if (ndone != 1) begin
            n_err++;
            $display("FAIL single_done: got %0d pulses want 1", ndone);
        end
        n_vec++;
        if (first != SETTLE) begin
            n_err++;
            $display("FAIL stall_latency: got %0d want %0d", first, SETTLE);
        end
        n_vec++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL settle_ignore: got %0d bad cycles want 0", bad);
        end
        n_vec++;
        if (got !== ref_cmp(16'h0A0A, 16'h0B0B)) begin
            n_err++;
            $display("FAIL stall_flags: got %b want %b", got, ref_cmp(16'h0A0A, 16'h0B0B));
        end
        n_vec++;
        if ({busy, din_ready} !== 2'b00) begin
            n_err++;
            $display("FAIL no_restart: got busy/rdy=%b want 00", {busy, din_ready});
        end
    endtask

    task automatic test_reset_mid();
        int n;
        int ndone = 0;
        int nbusy = 0;
        load_ops(16'hABCD, 16'h1234);
        for (int j = 0; j < 28; j++) tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        n_vec++;
        if ({op_a, op_b, eq, ae, gt, d, done, busy} !== 41'h0) begin
            n_err++;
            $display("FAIL midreset_outs: got %h/%h flags=%b done=%b busy=%b want all 0",
                     op_a, op_b, {eq, ae, gt, d}, done, busy);
        end
        for (int j = 0; j < 70; j++) begin
            tick();
            if (done === 1'b1) ndone++;
            if (busy === 1'b1) nbusy++;
        end
        n_vec++;
        if (ndone != 0 || nbusy != 0) begin
            n_err++;
            $display("FAIL midreset_abort: got %0d done %0d busy want 0 0", ndone, nbusy);
        end
        load_ops(16'h00F0, 16'h00F0);
        wait_done(n);
        n_vec++;
        if (n != SETTLE) begin
            n_err++;
            $display("FAIL post_reset_latency: got %0d want %0d", n, SETTLE);
        end
        n_vec++;
        if ({eq, ae, gt, d} !== 7'b1101111) begin
            n_err++;
            $display("FAIL post_reset_flags: got %b want 1101111", {eq, ae, gt, d});
        end
    endtask

    task automatic test_back_to_back();
        int n;
        logic [15:0] a2;
        logic [15:0] b2;
        load_ops(16'($urandom), 16'($urandom));
        wait_done(n);
        n_vec++;
        if (n != SETTLE) begin
            n_err++;
            $display("FAIL b2b_first_latency: got %0d want %0d", n, SETTLE);
        end
        // start is asserted in the done cycle. That cycle is IDLE.
        start = 1'b1;
        tick();
        start = 1'b0;
        n_vec++;
        if ({din_ready, busy} !== 2'b11) begin
            n_err++;
            $display("FAIL b2b_accept: got rdy/busy=%b want 11", {din_ready, busy});
        end
        a2 = 16'($urandom);
        b2 = a2;
        din = a2;
        din_valid = 1'b1;
        tick();
        din = b2;
        tick();
        din_valid = 1'b0;
        wait_done(n);
        n_vec++;
        if (n != SETTLE || {eq, ae, gt, d} !== ref_cmp(a2, b2)) begin
            n_err++;
            $display("FAIL b2b_second: got lat=%0d flags=%b want %0d %b",
                     n, {eq, ae, gt, d}, SETTLE, ref_cmp(a2, b2));
        end
    endtask

    task automatic test_random();
        int n;
        logic [15:0] a;
        logic [15:0] b;
        for (int it = 0; it < 24; it++) begin
            a = 16'($urandom);
            case ($urandom_range(0, 3))
                0: b = 16'($urandom);
                1: b = a;
                2: b = 16'(-a);
                default: b = {a[15:8], 8'($urandom)};
            endcase
            load_ops(a, b);
            wait_done(n);
            n_vec++;
            if (n != SETTLE || {eq, ae, gt, d} !== ref_cmp(a, b) || op_a !== a || op_b !== b) begin
                n_err++;
                $display("FAIL rand_%0d: A=%h B=%h got lat=%0d flags=%b ops=%h/%h want %0d %b",
                         it, a, b, n, {eq, ae, gt, d}, op_a, op_b, SETTLE, ref_cmp(a, b));
            end
        end
    endtask

`ifdef MFC_MATCH_COUNT_EN
    task automatic test_match_count();
        int n;
        int nto = 0;
        logic [15:0] a;
        rst = 1'b0;
        tick();
        rst = 1'b1;
        n_vec++;
        if (match_cnt !== 8'd0) begin
            n_err++;
            $display("FAIL mc_reset: got %0d want 0", match_cnt);
        end
        for (int j = 0; j < 4; j++) begin
            a = 16'($urandom);
            load_ops(a, (j == 2) ? (a ^ 16'h0001) : a);
            wait_done(n);
            if (n < 0) nto++;
        end
        n_vec++;
        if (match_cnt !== 8'd3 || nto != 0) begin
            n_err++;
            $display("FAIL mc_three: got %0d (timeouts %0d) want 3", match_cnt, nto);
        end
        for (int j = 0; j < 257; j++) begin
            a = 16'($urandom);
            load_ops(a, a);
            wait_done(n);
            if (n < 0) nto++;
        end
        n_vec++;
        if (match_cnt !== 8'd255 || nto != 0) begin
            n_err++;
            $display("FAIL mc_saturate: got %0d (timeouts %0d) want 255", match_cnt, nto);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_equal();
        test_signed_boundary();
        test_negative();
        test_stall_and_ignore();
        test_reset_mid();
        test_back_to_back();
        test_random();
`ifdef MFC_MATCH_COUNT_EN
        test_match_count();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mfc_operand_sequencer.md
Name: mfc_operand_sequencer

Overview:
- Sequential front/back-end for the 16-bit multi-function comparator (eq / ae / gt / nibble-equal d).
- Accepts A then B over a single 16-bit valid/ready input stream and drives them stably onto the comparator inputs.
- Waits a fixed settle interval to cover the comparator's long combinational delay, then registers its flags and pulses done.
- Sits directly upstream (operand feed) and downstream (result capture) of the comparator.

Parameters:
- SETTLE_CYCLES, 58, clock cycles between B load and flag capture; must be >= 1; 58 covers a 576 ns comparator delay at a 10 ns clock.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-low reset.
- start  input  1  begin a comparison; honoured only in IDLE.
- din  input  16  operand data; A first, then B.
- din_valid  input  1  din holds a valid operand.
- din_ready  output  1  sequencer can accept an operand this cycle.
- op_a  output  16  registered A, to comparator input A.
- op_b  output  16  registered B, to comparator input B.
- cmp_eq, cmp_ae, cmp_gt  input  1 each  comparator flag outputs.
- cmp_d  input  4  comparator nibble-equal flags.
- eq, ae, gt  output  1 each  captured flags.
- d  output  4  captured nibble flags.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle pulse when flags are captured.

Behaviour:
- Reset: sampled at the clock edge while rst==0. Forces state IDLE, settle counter = 0, and op_a, op_b, eq, ae, gt, d, done, busy = 0. Reset mid-operation aborts the operation immediately; no done pulse is produced.
- FSM has four states: IDLE, LOAD_A, LOAD_B, SETTLE.
- IDLE:
  - din_ready = 0.
  - start==1 -> LOAD_A.
- LOAD_A:
  - din_ready = 1.
  - Edge with din_valid==1: op_a <= din, -> LOAD_B.
  - No transfer: state holds.
- LOAD_B:
  - din_ready = 1.
  - Edge with din_valid==1 (edge k): op_b <= din, counter <= SETTLE_CYCLES-1, -> SETTLE.
- SETTLE:
  - din_ready = 0.
  - Counter decrements by 1 each edge.
  - At the edge where the counter == 0 (edge k+SETTLE_CYCLES): eq, ae, gt, d <= cmp_*; done <= 1; -> IDLE.
  - With SETTLE_CYCLES==1, capture happens at edge k+1.
- done is high for exactly one cycle, then 0. That cycle is in IDLE, so a start in that cycle is accepted.
- start outside IDLE is ignored; there is no queuing.
- din_valid outside LOAD_A/LOAD_B is ignored and no data is consumed.
- op_a and op_b change only on their own load edge, and hold through SETTLE and afterwards until the next load.
- eq, ae, gt, d hold their last captured value until the next capture or reset.
- Counter width is $clog2(SETTLE_CYCLES+1). Down-count only; no wrap is possible because SETTLE is left at 0.
- Operands are passed through unmodified; all sign and magnitude interpretation stays in the comparator.

Optional Feature:
- Macro: MFC_MATCH_COUNT_EN.
- Defined:
  - Adds output match_cnt [7:0].
  - Reset value 0.
  - Increments by 1 on every capture edge where cmp_eq==1.
  - Saturates at 255; it does not wrap.
  - Cleared only by reset.
- Not defined: port and logic are absent; all other behaviour is identical.

Test Plan:
- Bench conditions for all scenarios: real comparator attached, 10 ns clock, SETTLE_CYCLES=58.
- Reset, then start; A=0x1234, B=0x1234 -> done exactly 58 edges after B accept; eq=1, ae=1, gt=0, d=4'b1111.
- A=0x8001, B=0x7FFF -> eq=0, ae=1, gt=0, d=4'b0000; op_a/op_b stable for all 58 settle cycles.
- A=0x0005, B=0xFFFB -> eq=0, ae=1, gt=1, d=4'b0000.
- din_valid held low for 5 cycles in LOAD_A, and start pulsed during SETTLE -> no load and no restart; single done pulse; din_ready=0 in IDLE/SETTLE.
- rst=0 for one edge during SETTLE (counter ~30) -> all outputs 0, no done pulse; next full A=0x00F0, B=0x00F0 run completes normally with eq=1, d=4'b1111.
- MFC_MATCH_COUNT_EN defined: 3 equal-operand runs plus 1 unequal run -> match_cnt=3. Force 260 equal runs -> match_cnt=255.
